// File: rtl/ram_fifo_ctrl.sv
// Push/pop queue controller that owns both ports of the 16x8 dual-port ram.
// Optional almost_full/almost_empty flags are enabled with `define FIFO_ALMOST_FLAGS_EN.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 4,
  parameter int DEPTH           = 16,
`ifdef FIFO_ALMOST_FLAGS_EN
  parameter int ALMOST_FULL_TH  = DEPTH - 2,
  parameter int ALMOST_EMPTY_TH = 2,
`endif
  parameter int RD_LATENCY      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic                  almost_full,
  output logic                  almost_empty,
`endif
  output logic                  ram_wr_enb,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_enb,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [CNT_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      rd_ptr;
  logic                  push_acc;
  logic                  pop_acc;
  logic [RD_LATENCY-1:0] rd_vld_p;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (wr_ptr == rd_ptr);
  assign push_acc = push & ~full;
  assign pop_acc  = pop & ~empty;

  assign ram_wr_enb  = push_acc;
  assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_data = push_data;
  assign ram_rd_enb  = pop_acc;
  assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + CNT_W'(push_acc);
      rd_ptr <= rd_ptr + CNT_W'(pop_acc);
      if (push && full)
        overflow <= 1'b1;
      if (pop && empty)
        underflow <= 1'b1;
    end
  end

  // ---- read-valid pipeline: one stage per RAM read latency edge ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_vld_p <= '0;
    end else begin
      rd_vld_p[0] <= pop_acc;
      for (int i = 1; i < RD_LATENCY; i++)
        rd_vld_p[i] <= rd_vld_p[i-1];
    end
  end

  // ---- output stage: capture RAM data when the oldest read matures ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      pop_valid <= 1'b0;
      pop_data  <= '0;
    end else begin
      pop_valid <= rd_vld_p[RD_LATENCY-1];
      if (rd_vld_p[RD_LATENCY-1])
        pop_data <= ram_rd_data;
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  logic [CNT_W-1:0] count_nxt;

  // Flags follow next-state occupancy so they move on the same edge as count.
  assign count_nxt = count + CNT_W'(push_acc) - CNT_W'(pop_acc);

  always_ff @(posedge clk) begin
    if (!rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_nxt >= CNT_W'(ALMOST_FULL_TH));
      almost_empty <= (count_nxt <= CNT_W'(ALMOST_EMPTY_TH));
    end
  end
`else
  // Almost flags are not present in this build.
`endif

endmodule
